pifo_reg_hs: RTL and testbench
==============================

PIFO_REG_HS -- requirements
Module: pifo_reg_hs

Interface
REQ-001 Parameter L2_MAX_SIZE, default 3: log2 of the number of entries; MAX_SIZE = 2**L2_MAX_SIZE.
REQ-002 Parameter RANK_WIDTH, default 16: rank width in bits.
REQ-003 Parameter META_WIDTH, default 32: metadata width in bits.
REQ-004 Parameter ORDER, default 0: 0 = dequeue smallest rank, 1 = dequeue largest rank.
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 ins_valid  in  1  insert request.
REQ-008 ins_ready  out  1  insert accepted when ins_valid && ins_ready.
REQ-009 ins_rank  in  RANK_WIDTH  rank of the inserted entry.
REQ-010 ins_meta  in  META_WIDTH  metadata of the inserted entry.
REQ-011 deq_valid  out  1  head entry available.
REQ-012 deq_ready  in  1  dequeue taken when deq_valid && deq_ready.
REQ-013 deq_rank  out  RANK_WIDTH  head rank, registered.
REQ-014 deq_meta  out  META_WIDTH  head metadata, registered.
REQ-015 count  out  L2_MAX_SIZE+1  number of stored entries.
REQ-016 full, empty  out  1 each  count==MAX_SIZE and count==0, respectively.
REQ-017 drop_cnt  out  16  saturating count of dropped inserts; present only with PIFO_REG_DROP_EN.

Function
REQ-018 Entries SHALL be held in arrival order at indices 0..count-1.
REQ-019 A dequeue SHALL remove the head index, shift higher entries down by one, and decrement count.
REQ-020 An accepted insert SHALL write the entry at index count (after any same-cycle compaction) and increment count.
REQ-021 Simultaneous accepted insert and dequeue SHALL both take effect in the same cycle, leaving count unchanged.
REQ-022 The head SHALL be the valid entry with min rank (ORDER=0) or max rank (ORDER=1); on ties, the lowest index (oldest entry) wins.
REQ-023 The state machine SHALL have states EMPTY, CALC and READY.
  - EMPTY -> CALC on an accepted insert.
  - READY -> CALC on any accepted insert or dequeue.
  - CALC -> READY if count>0, else CALC -> EMPTY.
  - In CALC, the head index, deq_rank and deq_meta SHALL be registered from the current contents.
REQ-024 deq_valid SHALL be 1 only in READY.
REQ-025 Latency: insert accepted at edge N into an empty block -> deq_valid=1 after edge N+1.
REQ-026 Dequeue throughput SHALL be one per two cycles.
REQ-027 deq_rank/deq_meta SHALL hold their values while deq_valid=0.
REQ-028 An insert accepted during CALC SHALL be legal and SHALL force one further CALC cycle.
REQ-029 count SHALL never exceed MAX_SIZE and SHALL never underflow.
REQ-030 deq_ready while deq_valid=0 SHALL have no effect.

Reset
REQ-031 rst SHALL clear all entries and force:
  - state=EMPTY, count=0, empty=1, full=0;
  - deq_valid=0, deq_rank=0, deq_meta=0;
  - drop_cnt=0.
REQ-032 ins_ready SHALL be 1 during and after reset whenever the block is not full.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries immediately, with no output glitch after deassertion.

Configuration
REQ-034 Without PIFO_REG_DROP_EN: ins_ready = !full, and the drop_cnt port SHALL be absent.
REQ-035 With PIFO_REG_DROP_EN: ins_ready is constant 1, and an insert arriving while full with no same-cycle dequeue SHALL be discarded and SHALL increment drop_cnt, saturating at 16'hFFFF.

Structure
REQ-036 Package pifo_pkg SHALL hold the ORDER_MIN/ORDER_MAX constants and the state enumeration typedef.
REQ-037 Sub-module pifo_argsel SHALL be a combinational selector over MAX_SIZE ranks plus a valid mask, returning the winning index per ORDER with the lowest-index tie rule.

Verification
REQ-038 Reset, then insert rank 5 at edge 0 -> deq_valid=1 after edge 1, deq_rank=5, count=1.
REQ-039 ORDER=0, insert ranks 7,3,9,3 (meta 1,2,3,4), dequeue all -> meta order 2,4,1,3; empty=1 at the end.
REQ-040 ORDER=1, same stimulus as REQ-039 -> meta order 3,1,2,4.
REQ-041 L2_MAX_SIZE=3, insert 9 entries without PIFO_REG_DROP_EN -> full=1 and ins_ready=0 at count 8; the 9th entry is held and later accepted after a dequeue.
REQ-042 With PIFO_REG_DROP_EN, insert 10 entries into an 8-entry block -> drop_cnt=2, count=8.
REQ-043 With 4 entries stored, simultaneous insert and dequeue -> count stays 4, the head is recomputed with the new entry included, and rst asserted mid-sequence -> count=0, deq_valid=0.

Source files
------------

// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared ORDER constants and state encoding for the register PIFO
package pifo_pkg;

    localparam int ORDER_MIN = 0;
    localparam int ORDER_MAX = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        CALC  = 2'd1,
        READY = 2'd2
    } pifo_state_e;

endpackage

// File: rtl/pifo_argsel.sv
// rtl/pifo_argsel.sv - combinational min/max rank selector over a valid mask
// Strict comparison while scanning upward keeps the lowest (oldest) index on ties.
module pifo_argsel
    import pifo_pkg::*;
#(
    parameter int N_ENT      = 8,
    parameter int IDX_W      = 3,
    parameter int RANK_WIDTH = 16,
    parameter int ORDER      = ORDER_MIN
) (
    input  logic [RANK_WIDTH-1:0] ranks [N_ENT],
    input  logic [N_ENT-1:0]      valid,
    output logic [IDX_W-1:0]      sel_idx,
    output logic                  sel_valid
);

    logic [RANK_WIDTH-1:0] best_rank;

    function automatic logic beats(input logic [RANK_WIDTH-1:0] a,
                                   input logic [RANK_WIDTH-1:0] b);
        return (ORDER == ORDER_MAX) ? (a > b) : (a < b);
    endfunction

    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        best_rank = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (valid[i] && (!sel_valid || beats(ranks[i], best_rank))) begin
                sel_idx   = IDX_W'(i);
                sel_valid = 1'b1;
                best_rank = ranks[i];
            end
        end
    end

endmodule

// File: rtl/pifo_reg_hs.sv
// rtl/pifo_reg_hs.sv - register-array PIFO with valid/ready insert and registered head output
// Optional PIFO_REG_DROP_EN: insert side always ready; inserts arriving while full are dropped and counted.
module pifo_reg_hs
    import pifo_pkg::*;
#(
    parameter int L2_MAX_SIZE = 3,
    parameter int RANK_WIDTH  = 16,
    parameter int META_WIDTH  = 32,
    parameter int ORDER       = ORDER_MIN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    input  logic [RANK_WIDTH-1:0]  ins_rank,
    input  logic [META_WIDTH-1:0]  ins_meta,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [RANK_WIDTH-1:0]  deq_rank,
    output logic [META_WIDTH-1:0]  deq_meta,
    output logic [L2_MAX_SIZE:0]   count,
    output logic                   full,
    output logic                   empty
`ifdef PIFO_REG_DROP_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int MAX_SIZE = 2 ** L2_MAX_SIZE;
    localparam int CW       = L2_MAX_SIZE + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SIZE);

    pifo_state_e             state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [RANK_WIDTH-1:0]   rank_q [MAX_SIZE];
    logic [RANK_WIDTH-1:0]   rank_d [MAX_SIZE];
    logic [META_WIDTH-1:0]   meta_q [MAX_SIZE];
    logic [META_WIDTH-1:0]   meta_d [MAX_SIZE];
    logic [L2_MAX_SIZE-1:0]  head_q, head_d;
    logic [RANK_WIDTH-1:0]   deq_rank_q, deq_rank_d;
    logic [META_WIDTH-1:0]   deq_meta_q, deq_meta_d;

    logic [MAX_SIZE-1:0]     valid_mask;
    logic [L2_MAX_SIZE-1:0]  sel_idx;
    logic                    sel_valid;
    logic                    deq_fire;
    logic                    ins_fire;
    logic                    ins_write;
    logic [CW-1:0]           wr_idx;

`ifdef PIFO_REG_DROP_EN
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    assign drop_cnt = drop_cnt_q;
`endif

    pifo_argsel #(
        .N_ENT      (MAX_SIZE),
        .IDX_W      (L2_MAX_SIZE),
        .RANK_WIDTH (RANK_WIDTH),
        .ORDER      (ORDER)
    ) u_argsel (
        .ranks     (rank_q),
        .valid     (valid_mask),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid)
    );

    always_comb begin
        full  = (count_q == MAX_CNT);
        empty = (count_q == '0);
`ifdef PIFO_REG_DROP_EN
        ins_ready = 1'b1;
`else
        ins_ready = !full;
`endif
        deq_fire  = (state_q == READY) && deq_ready;
        ins_fire  = ins_valid && ins_ready;
        // A full array still takes the insert when the head leaves in the same cycle.
        ins_write = ins_fire && (!full || deq_fire);
        wr_idx    = deq_fire ? (count_q - CW'(1)) : count_q;

        for (int i = 0; i < MAX_SIZE; i++) begin
            valid_mask[i] = (CW'(i) < count_q);
        end

        rank_d = rank_q;
        meta_d = meta_q;
        if (deq_fire) begin
            for (int i = 0; i < MAX_SIZE - 1; i++) begin
                if (i >= int'(head_q)) begin
                    rank_d[i] = rank_q[i+1];
                    meta_d[i] = meta_q[i+1];
                end
            end
        end
        if (ins_write) begin
            for (int i = 0; i < MAX_SIZE; i++) begin
                if (CW'(i) == wr_idx) begin
                    rank_d[i] = ins_rank;
                    meta_d[i] = ins_meta;
                end
            end
        end

        count_d = count_q;
        if (ins_write && !deq_fire) begin
            count_d = count_q + CW'(1);
        end else if (deq_fire && !ins_write) begin
            count_d = count_q - CW'(1);
        end

        head_d     = head_q;
        deq_rank_d = deq_rank_q;
        deq_meta_d = deq_meta_q;
        if ((state_q == CALC) && sel_valid) begin
            head_d     = sel_idx;
            deq_rank_d = rank_q[sel_idx];
            deq_meta_d = meta_q[sel_idx];
        end

`ifdef PIFO_REG_DROP_EN
        drop_cnt_d = drop_cnt_q;
        if (ins_fire && !ins_write && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (ins_write) state_d = CALC;
            end
            CALC: begin
                // Contents changed under the selector, so take another look.
                if (ins_write)            state_d = CALC;
                else if (count_q != '0)   state_d = READY;
                else                      state_d = EMPTY;
            end
            READY: begin
                if (ins_write || deq_fire) state_d = CALC;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            head_q     <= '0;
            deq_rank_q <= '0;
            deq_meta_q <= '0;
            for (int i = 0; i < MAX_SIZE; i++) begin
                rank_q[i] <= '0;
                meta_q[i] <= '0;
            end
`ifdef PIFO_REG_DROP_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_q     <= head_d;
            deq_rank_q <= deq_rank_d;
            deq_meta_q <= deq_meta_d;
            rank_q     <= rank_d;
            meta_q     <= meta_d;
`ifdef PIFO_REG_DROP_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign deq_valid = (state_q == READY);
    assign deq_rank  = deq_rank_q;
    assign deq_meta  = deq_meta_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pifo_reg_hs.sv
// tb/tb_pifo_reg_hs.sv - self-checking bench for pifo_reg_hs, ORDER=0 and ORDER=1 side by side
module tb_pifo_reg_hs;

    localparam int MAX = 8;

    typedef struct {
        logic [15:0] r;
        logic [31:0] m;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic [15:0] ins_rank;
    logic [31:0] ins_meta;
    logic        deq_ready;

    logic        ins_ready_o [2];
    logic        deq_valid_o [2];
    logic [15:0] deq_rank_o  [2];
    logic [31:0] deq_meta_o  [2];
    logic [3:0]  count_o     [2];
    logic        full_o      [2];
    logic        empty_o     [2];
    logic [15:0] drop_o      [2];

    ent_t        mq      [2][$];
    logic [31:0] log_q   [2][$];
    int          acc_cnt [2];
    int          drop_m  [2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    pifo_reg_hs #(.L2_MAX_SIZE(3), .RANK_WIDTH(16), .META_WIDTH(32), .ORDER(0)) dut0 (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready_o[0]),
        .ins_rank(ins_rank), .ins_meta(ins_meta), .deq_valid(deq_valid_o[0]),
        .deq_ready(deq_ready), .deq_rank(deq_rank_o[0]), .deq_meta(deq_meta_o[0]),
        .count(count_o[0]), .full(full_o[0]), .empty(empty_o[0])
`ifdef PIFO_REG_DROP_EN
        , .drop_cnt(drop_o[0])
`endif
    );

    pifo_reg_hs #(.L2_MAX_SIZE(3), .RANK_WIDTH(16), .META_WIDTH(32), .ORDER(1)) dut1 (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready_o[1]),
        .ins_rank(ins_rank), .ins_meta(ins_meta), .deq_valid(deq_valid_o[1]),
        .deq_ready(deq_ready), .deq_rank(deq_rank_o[1]), .deq_meta(deq_meta_o[1]),
        .count(count_o[1]), .full(full_o[1]), .empty(empty_o[1])
`ifdef PIFO_REG_DROP_EN
        , .drop_cnt(drop_o[1])
`endif
    );

`ifndef PIFO_REG_DROP_EN
    assign drop_o[0] = 16'd0;
    assign drop_o[1] = 16'd0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Head = oldest entry holding the best rank (smallest for ord 0, largest for ord 1).
    function automatic int best(input ent_t q[$], input int ord);
        int b = -1;
        foreach (q[i]) begin
            if (b < 0 || (ord == 0 ? q[i].r < q[b].r : q[i].r > q[b].r)) b = i;
        end
        return b;
    endfunction

    task automatic step();
        bit   dfire [2];
        bit   acc   [2];
        int   b     [2];
        ent_t e;
        #1;
        e.r = ins_rank;
        e.m = ins_meta;
        for (int d = 0; d < 2; d++) begin
            int sz = mq[d].size();
            chk($sformatf("d%0d_count", d), count_o[d], sz);
            chk($sformatf("d%0d_empty", d), empty_o[d], sz == 0);
            chk($sformatf("d%0d_full", d), full_o[d], sz == MAX);
`ifdef PIFO_REG_DROP_EN
            chk($sformatf("d%0d_ins_ready", d), ins_ready_o[d], 1);
            chk($sformatf("d%0d_drop_cnt", d), drop_o[d], drop_m[d]);
`else
            chk($sformatf("d%0d_ins_ready", d), ins_ready_o[d], sz < MAX);
`endif
            b[d] = best(mq[d], d);
            if (deq_valid_o[d]) begin
                if (b[d] < 0) begin
                    chk($sformatf("d%0d_valid_when_empty", d), deq_valid_o[d], 0);
                end else begin
                    chk($sformatf("d%0d_head_rank", d), deq_rank_o[d], mq[d][b[d]].r);
                    chk($sformatf("d%0d_head_meta", d), deq_meta_o[d], mq[d][b[d]].m);
                end
            end
            dfire[d] = deq_valid_o[d] && deq_ready && (b[d] >= 0);
            acc[d]   = ins_valid && ins_ready_o[d] && (sz < MAX || dfire[d]);
            if (ins_valid && ins_ready_o[d] && !acc[d] && drop_m[d] != 16'hFFFF) drop_m[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            if (dfire[d]) begin
                log_q[d].push_back(deq_meta_o[d]);
                mq[d].delete(b[d]);
            end
            if (acc[d]) begin
                mq[d].push_back(e);
                acc_cnt[d]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ins_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_count", d), count_o[d], 0);
            chk($sformatf("d%0d_rst_empty", d), empty_o[d], 1);
            chk($sformatf("d%0d_rst_full", d), full_o[d], 0);
            chk($sformatf("d%0d_rst_deq_valid", d), deq_valid_o[d], 0);
            chk($sformatf("d%0d_rst_deq_rank", d), deq_rank_o[d], 0);
            chk($sformatf("d%0d_rst_deq_meta", d), deq_meta_o[d], 0);
            chk($sformatf("d%0d_rst_ins_ready", d), ins_ready_o[d], 1);
            chk($sformatf("d%0d_rst_drop", d), drop_o[d], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            log_q[d].delete();
            acc_cnt[d] = 0;
            drop_m[d]  = 0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!(deq_valid_o[0] && deq_valid_o[1]) && n < 10) begin
            step();
            n++;
        end
        chk(tag, {deq_valid_o[0], deq_valid_o[1]}, 2'b11);
    endtask

    initial begin
        logic [15:0] ranks4 [4];
        logic [31:0] exp0   [4];
        logic [31:0] exp1   [4];
        ranks4 = '{16'd7, 16'd3, 16'd9, 16'd3};
        exp0   = '{32'd2, 32'd4, 32'd1, 32'd3};
        exp1   = '{32'd3, 32'd1, 32'd2, 32'd4};
        rst = 1'b1; ins_valid = 1'b0; deq_ready = 1'b0; ins_rank = '0; ins_meta = '0;
        @(negedge clk);
        do_reset();

        // Single insert latency
        ins_valid = 1'b1; ins_rank = 16'd5; ins_meta = 32'hA5;
        step();
        ins_valid = 1'b0;
        chk("lat_valid_after_edge0", deq_valid_o[0], 0);
        step();
        chk("lat_valid_after_edge1", deq_valid_o[0], 1);
        chk("lat_rank", deq_rank_o[0], 5);
        chk("lat_count", count_o[0], 1);

        // Ordering with ties, both ORDER settings
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ins_valid = 1'b1; ins_rank = ranks4[k]; ins_meta = 32'(k + 1);
            step();
        end
        ins_valid = 1'b0;
        deq_ready = 1'b1;
        for (int n = 0; n < 40 && (mq[0].size() != 0 || mq[1].size() != 0); n++) step();
        deq_ready = 1'b0;
        chk("order0_len", log_q[0].size(), 4);
        chk("order1_len", log_q[1].size(), 4);
        for (int k = 0; k < 4 && k < log_q[0].size(); k++) chk($sformatf("order0_meta%0d", k), log_q[0][k], exp0[k]);
        for (int k = 0; k < 4 && k < log_q[1].size(); k++) chk($sformatf("order1_meta%0d", k), log_q[1][k], exp1[k]);
        chk("order0_empty", empty_o[0], 1);
        chk("order1_empty", empty_o[1], 1);

        // Filling past capacity
        do_reset();
        ins_valid = 1'b1;
`ifdef PIFO_REG_DROP_EN
        for (int k = 0; k < 10; k++) begin
            ins_rank = 16'($urandom_range(0, 31)); ins_meta = 32'(300 + k);
            step();
        end
        ins_valid = 1'b0;
        chk("drop_count8", count_o[0], 8);
        chk("drop_cnt2", drop_o[0], 2);
        chk("drop_full", full_o[0], 1);
`else
        for (int k = 0; k < 12; k++) begin
            ins_rank = 16'($urandom_range(0, 31)); ins_meta = 32'(200 + acc_cnt[0]);
            step();
        end
        chk("fill_count8", count_o[0], 8);
        chk("fill_full", full_o[0], 1);
        chk("fill_ins_ready0", ins_ready_o[0], 0);
        for (int n = 0; n < 30 && acc_cnt[0] < 9; n++) begin
            deq_ready = (log_q[0].size() == 0);
            step();
        end
        deq_ready = 1'b0;
        ins_valid = 1'b0;
        chk("ninth_count", count_o[0], 8);
        wait_valid("ninth_head_valid");
        step();
`endif

        // Simultaneous insert and dequeue, then asynchronous mid-run reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ins_valid = 1'b1; ins_rank = 16'(10 * (k + 1)); ins_meta = 32'(50 + k);
            step();
        end
        ins_valid = 1'b0;
        wait_valid("sim_pre_valid");
        ins_valid = 1'b1; ins_rank = 16'd1; ins_meta = 32'd99; deq_ready = 1'b1;
        step();
        ins_valid = 1'b0; deq_ready = 1'b0;
        chk("sim_count0", count_o[0], 4);
        chk("sim_count1", count_o[1], 4);
        wait_valid("sim_post_valid");
        chk("sim_head0_rank", deq_rank_o[0], 1);
        chk("sim_head0_meta", deq_meta_o[0], 99);
        chk("sim_head1_rank", deq_rank_o[1], 30);
        ins_valid = 1'b1; ins_rank = 16'd2; ins_meta = 32'd77;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_count", count_o[0], 0);
        chk("midrst_valid", deq_valid_o[0], 0);
        chk("midrst_empty", empty_o[1], 1);
        ins_valid = 1'b0;
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_idle_valid", deq_valid_o[0] | deq_valid_o[1], 0);
        end

        // Randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ins_valid = ($urandom_range(0, 99) < (n < 200 ? 60 : 25));
            ins_rank  = 16'($urandom_range(0, 7));
            ins_meta  = $urandom;
            deq_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        ins_valid = 1'b0;
        deq_ready = 1'b1;
        for (int n = 0; n < 40 && (mq[0].size() != 0 || mq[1].size() != 0); n++) step();
        deq_ready = 1'b0;
        step();
        chk("rand_drained0", empty_o[0], 1);
        chk("rand_drained1", empty_o[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
